post_target_master: RTL and testbench
=====================================

Name: post_target_master

Overview:
- Target-side initiator of the Acorn POST box pulse protocol: the other end of the adapter (post_box_usb) that answers testreq pulses with testack.
- Takes one command at a time from a local controller: sync, clear, output byte, or input byte.
- Generates the testreq pulse train, samples testack and returns a status and read data.
- Used as a bench/board-level target emulator to exercise the adapter through the real pulse interface.

Parameters:
- PWID_CYCLES, 24, testreq high time per pulse in clocks (500 ns at 48 MHz).
- PGAP_CYCLES, 24, testreq low time between pulses inside a group.
- BREAK_CYCLES, 1200, testreq low time after the last pulse of a group (25 us).

Ports:
- fpga_clock_48mhz  input  1  single clock; all logic on its rising edge.
- reset_in  input  1  synchronous, active-high reset.
- cmd_valid  input  1  command request.
- cmd_ready  output  1  high only in IDLE; command accepted when cmd_valid && cmd_ready.
- cmd_op  input  2  0=SYNC, 1=OUTPUT, 2=INPUT, 3=CLEAR.
- cmd_data  input  8  byte to send for OUTPUT; ignored otherwise.
- rsp_valid  output  1  one-cycle pulse when a command completes.
- rsp_ok  output  1  ready-ack seen (meaning per op below); valid with rsp_valid.
- rsp_data  output  8  byte received by INPUT; holds until the next rsp_valid.
- busy  output  1  high from acceptance until the rsp_valid cycle inclusive.
- testreq  output  1  registered pulse output to the adapter.
- testack  input  1  asynchronous ack from the adapter; synchronised by 2 flops internally (ack_s).

Behaviour:
- Reset (synchronous, active high):
  - testreq=0, rsp_valid=0, rsp_ok=0, rsp_data=0, busy=0, cmd_ready=1, FSM=IDLE, all counters=0.
  - Reset mid-command aborts the command immediately; no rsp_valid is issued.
- Pulse timing:
  - testreq rises on the cycle after acceptance.
  - Each pulse is exactly PWID_CYCLES high.
  - Pulses inside a group are separated by PGAP_CYCLES low.
  - A group ends with BREAK_CYCLES low.
- Ack sampling: ack_s is sampled in the last high cycle of a pulse ("sample").
- FSM states: IDLE, HIGH, GAP, BREAK, RESP.
  - IDLE -> HIGH on accept.
  - HIGH -> GAP, or HIGH -> BREAK if this was the group's last pulse.
  - GAP -> HIGH.
  - BREAK -> HIGH if another group follows, else BREAK -> RESP.
  - RESP -> IDLE after one cycle. rsp_valid=1 in RESP only.
- SYNC: one group of 4 pulses. rsp_ok = sample of pulse 4.
- CLEAR: one group of 12 pulses. rsp_ok=0.
- OUTPUT:
  - Group of 3 pulses; ready = sample of pulse 3.
  - ready=0: rsp_ok=0 after the break; no data is sent.
  - ready=1: 8 more groups follow, MSB first. Bit 1 = group of 1 pulse; bit 0 = group of 2 pulses; every group ends with a break.
  - rsp_ok=1 on completion.
- INPUT:
  - Pulses 1..4, then a gap.
  - If the sample of pulse 4 is 0: pulse 4 ends the group (break), rsp_ok=0, rsp_data unchanged.
  - If it is 1: pulses 5..12 continue in the same group (gaps, no break). The sample of pulse 5+i is rsp_data bit 7-i. The break follows pulse 12.
  - rsp_ok=1; rsp_data updated in the RESP cycle.
- Counters:
  - Timer sized for max(PWID_CYCLES, PGAP_CYCLES, BREAK_CYCLES).
  - Pulse-in-group counter 4 bits; bit index 3 bits; no wrap beyond 12.
- Boundary rules:
  - cmd_valid while busy is ignored (cmd_ready=0). cmd_op/cmd_data are captured at acceptance.
  - A testack change mid-pulse affects only the sample cycle.
  - A command may be accepted in the cycle after RESP.

Test Plan:
- Reset, then SYNC with testack tied 0 -> exactly 4 pulses of 24 clk high / 24 low, 1200 clk low, then rsp_valid=1, rsp_ok=0; cmd_ready=0 throughout.
- OUTPUT 0xA8 against an adapter model with ready=1 -> 3 pulses, then groups 1,2,1,2,1,2,2,2 pulses; adapter model reconstructs 0xA8; rsp_ok=1.
- OUTPUT with ready=0 (ack 0 on pulse 3) -> only 3 pulses + break; rsp_ok=0; no data groups.
- INPUT with adapter holding 0x42 -> 12 pulses in one group; rsp_ok=1, rsp_data=0x42. Repeat with 0xC3 -> 0xC3.
- INPUT with adapter empty -> 4 pulses + break; rsp_ok=0; rsp_data keeps 0xC3.
- Assert reset_in during pulse 6 of an INPUT -> testreq=0 the next cycle, no rsp_valid; the following SYNC runs normally.

Source files
------------

// File: rtl/post_target_master_if.sv
// Command/response bundle between a local controller and post_target_master.
//   cmd_valid/cmd_ready/cmd_op/cmd_data : one command at a time, accepted on valid && ready
//   rsp_valid/rsp_ok/rsp_data           : completion pulse, status and received byte
//   busy                                : command in flight, up to and including rsp_valid
// The master modport is the controller side; the slave modport is the pulse engine.
interface post_target_master_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [7:0] cmd_data;
    logic       rsp_valid;
    logic       rsp_ok;
    logic [7:0] rsp_data;
    logic       busy;

    modport master (
        output cmd_valid, cmd_op, cmd_data,
        input  cmd_ready, rsp_valid, rsp_ok, rsp_data, busy
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_data,
        output cmd_ready, rsp_valid, rsp_ok, rsp_data, busy
    );
endinterface

// File: rtl/post_target_master.sv
// Target-side initiator of the Acorn POST box pulse protocol.
// Runs one SYNC / OUTPUT / INPUT / CLEAR command at a time, producing testreq
// pulse groups and sampling the adapter's testack in the last high cycle of each pulse.
// Ports:
//   fpga_clock_48mhz : single clock, rising edge
//   reset_in         : synchronous active-high reset; aborts any command silently
//   bus              : command/response bundle (slave modport)
//   testreq          : registered pulse output to the adapter
//   testack          : asynchronous ack from the adapter, double-synchronised to ack_s
module post_target_master #(
    parameter int PWID_CYCLES  = 24,
    parameter int PGAP_CYCLES  = 24,
    parameter int BREAK_CYCLES = 1200
) (
    input  logic                 fpga_clock_48mhz,
    input  logic                 reset_in,
    post_target_master_if.slave  bus,
    output logic                 testreq,
    input  logic                 testack
);
    localparam int T_MAX_A = (PWID_CYCLES > PGAP_CYCLES) ? PWID_CYCLES : PGAP_CYCLES;
    localparam int T_MAX   = (T_MAX_A > BREAK_CYCLES) ? T_MAX_A : BREAK_CYCLES;
    localparam int TW      = $clog2(T_MAX + 1);

    localparam logic [TW-1:0] PWID_LAST  = TW'(PWID_CYCLES - 1);
    localparam logic [TW-1:0] PGAP_LAST  = TW'(PGAP_CYCLES - 1);
    localparam logic [TW-1:0] BREAK_LAST = TW'(BREAK_CYCLES - 1);

    localparam logic [1:0] OP_SYNC   = 2'd0;
    localparam logic [1:0] OP_OUTPUT = 2'd1;
    localparam logic [1:0] OP_INPUT  = 2'd2;
    localparam logic [1:0] OP_CLEAR  = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HIGH  = 3'd1,
        ST_GAP   = 3'd2,
        ST_BREAK = 3'd3,
        ST_RESP  = 3'd4
    } state_t;

    state_t          state_r, next_state_s;
    logic [TW-1:0]   timer_r, timer_next_s;
    logic [1:0]      op_r, op_next_s;
    logic [7:0]      data_r, data_next_s;
    logic [3:0]      pulse_cnt_r, pulse_cnt_next_s;   // pulses completed in current group
    logic [3:0]      pulse_num_s;                     // 1-based number of the pulse in flight
    logic [2:0]      bit_idx_r, bit_idx_next_s;
    logic            data_phase_r, data_phase_next_s; // OUTPUT: ready group done, sending bits
    logic            ok_r, ok_next_s;
    logic [7:0]      rx_r, rx_next_s;
    logic            last_pulse_s;

    logic            ack_meta_r;
    logic            ack_s;

    logic            testreq_r;
    logic            cmd_ready_r;
    logic            busy_r;
    logic            rsp_valid_r;
    logic            rsp_ok_r;
    logic [7:0]      rsp_data_r;

    assign pulse_num_s   = pulse_cnt_r + 4'd1;
    assign testreq       = testreq_r;
    assign bus.cmd_ready = cmd_ready_r;
    assign bus.busy      = busy_r;
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_ok    = rsp_ok_r;
    assign bus.rsp_data  = rsp_data_r;

    // Two-flop synchroniser for the asynchronous adapter ack.
    always_ff @(posedge fpga_clock_48mhz) begin
        if (reset_in) begin
            ack_meta_r <= 1'b0;
            ack_s      <= 1'b0;
        end else begin
            ack_meta_r <= testack;
            ack_s      <= ack_meta_r;
        end
    end

    // Decide whether the pulse now in flight closes its group.
    // INPUT stops after pulse 4 when the adapter has nothing to send.
    always_comb begin
        last_pulse_s = 1'b0;
        case (op_r)
            OP_SYNC:   last_pulse_s = (pulse_num_s == 4'd4);
            OP_CLEAR:  last_pulse_s = (pulse_num_s == 4'd12);
            OP_OUTPUT: begin
                if (data_phase_r) begin
                    // Data bit 1 is a single pulse, bit 0 a pair.
                    last_pulse_s = data_r[bit_idx_r] ? (pulse_num_s == 4'd1) : (pulse_num_s == 4'd2);
                end else begin
                    last_pulse_s = (pulse_num_s == 4'd3);
                end
            end
            OP_INPUT:  last_pulse_s = (pulse_num_s == 4'd12) || ((pulse_num_s == 4'd4) && !ack_s);
            default:   last_pulse_s = 1'b0;
        endcase
    end

    // Next-state and datapath update for the pulse sequencer.
    always_comb begin
        next_state_s      = state_r;
        timer_next_s      = timer_r + TW'(1);
        op_next_s         = op_r;
        data_next_s       = data_r;
        pulse_cnt_next_s  = pulse_cnt_r;
        bit_idx_next_s    = bit_idx_r;
        data_phase_next_s = data_phase_r;
        ok_next_s         = ok_r;
        rx_next_s         = rx_r;
        case (state_r)
            ST_IDLE: begin
                timer_next_s = '0;
                if (bus.cmd_valid) begin
                    next_state_s      = ST_HIGH;
                    op_next_s         = bus.cmd_op;
                    data_next_s       = bus.cmd_data;
                    pulse_cnt_next_s  = 4'd0;
                    bit_idx_next_s    = 3'd7;
                    data_phase_next_s = 1'b0;
                    ok_next_s         = 1'b0;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_HIGH: begin
                if (timer_r == PWID_LAST) begin
                    // Last high cycle: this is the only cycle where ack_s matters.
                    timer_next_s     = '0;
                    pulse_cnt_next_s = last_pulse_s ? 4'd0 : pulse_num_s;
                    next_state_s     = last_pulse_s ? ST_BREAK : ST_GAP;
                    case (op_r)
                        OP_SYNC: begin
                            if (pulse_num_s == 4'd4) begin
                                ok_next_s = ack_s;
                            end else begin
                                ok_next_s = ok_r;
                            end
                        end
                        OP_OUTPUT: begin
                            if (!data_phase_r && (pulse_num_s == 4'd3)) begin
                                ok_next_s = ack_s;
                            end else begin
                                ok_next_s = ok_r;
                            end
                        end
                        OP_INPUT: begin
                            if (pulse_num_s == 4'd4) begin
                                ok_next_s = ack_s;
                            end else if (pulse_num_s >= 4'd5) begin
                                // Pulses 5..12 carry the byte MSB first.
                                rx_next_s = {rx_r[6:0], ack_s};
                            end else begin
                                rx_next_s = rx_r;
                            end
                        end
                        default: ok_next_s = 1'b0;
                    endcase
                end else begin
                    next_state_s = ST_HIGH;
                end
            end
            ST_GAP: begin
                if (timer_r == PGAP_LAST) begin
                    timer_next_s = '0;
                    next_state_s = ST_HIGH;
                end else begin
                    next_state_s = ST_GAP;
                end
            end
            ST_BREAK: begin
                if (timer_r == BREAK_LAST) begin
                    timer_next_s = '0;
                    if ((op_r == OP_OUTPUT) && ok_r && !data_phase_r) begin
                        data_phase_next_s = 1'b1;
                        bit_idx_next_s    = 3'd7;
                        next_state_s      = ST_HIGH;
                    end else if ((op_r == OP_OUTPUT) && data_phase_r && (bit_idx_r != 3'd0)) begin
                        bit_idx_next_s = bit_idx_r - 3'd1;
                        next_state_s   = ST_HIGH;
                    end else begin
                        next_state_s = ST_RESP;
                    end
                end else begin
                    next_state_s = ST_BREAK;
                end
            end
            ST_RESP: begin
                timer_next_s = '0;
                next_state_s = ST_IDLE;
            end
            default: begin
                timer_next_s = '0;
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // State, datapath and registered outputs; outputs follow the next state so
    // testreq rises the cycle after acceptance and rsp_valid coincides with RESP.
    always_ff @(posedge fpga_clock_48mhz) begin
        if (reset_in) begin
            state_r      <= ST_IDLE;
            timer_r      <= '0;
            op_r         <= 2'd0;
            data_r       <= 8'd0;
            pulse_cnt_r  <= 4'd0;
            bit_idx_r    <= 3'd0;
            data_phase_r <= 1'b0;
            ok_r         <= 1'b0;
            rx_r         <= 8'd0;
            testreq_r    <= 1'b0;
            cmd_ready_r  <= 1'b1;
            busy_r       <= 1'b0;
            rsp_valid_r  <= 1'b0;
            rsp_ok_r     <= 1'b0;
            rsp_data_r   <= 8'd0;
        end else begin
            state_r      <= next_state_s;
            timer_r      <= timer_next_s;
            op_r         <= op_next_s;
            data_r       <= data_next_s;
            pulse_cnt_r  <= pulse_cnt_next_s;
            bit_idx_r    <= bit_idx_next_s;
            data_phase_r <= data_phase_next_s;
            ok_r         <= ok_next_s;
            rx_r         <= rx_next_s;
            testreq_r    <= (next_state_s == ST_HIGH);
            cmd_ready_r  <= (next_state_s == ST_IDLE);
            busy_r       <= (next_state_s != ST_IDLE);
            rsp_valid_r  <= (next_state_s == ST_RESP);
            if (next_state_s == ST_RESP) begin
                rsp_ok_r <= ok_r;
                if ((op_r == OP_INPUT) && ok_r) begin
                    rsp_data_r <= rx_r;
                end else begin
                    rsp_data_r <= rsp_data_r;
                end
            end else begin
                rsp_ok_r   <= rsp_ok_r;
                rsp_data_r <= rsp_data_r;
            end
        end
    end
endmodule

// File: tb/tb_post_target_master.sv
// Bench for post_target_master: plays the adapter end of the pulse link,
// measures every pulse/gap/break and compares group structure, status and
// data against expectations derived from the protocol rules.
module tb_post_target_master;
    localparam int PWID = 24;
    localparam int PGAP = 24;
    localparam int BRK  = 1200;
    localparam int MAX_CYCLES = 15000;

    localparam logic [1:0] OP_SYNC   = 2'd0;
    localparam logic [1:0] OP_OUTPUT = 2'd1;
    localparam logic [1:0] OP_INPUT  = 2'd2;
    localparam logic [1:0] OP_CLEAR  = 2'd3;

    logic clk = 1'b0;
    logic reset_in;
    logic testreq;
    logic testack;

    post_target_master_if bus();

    post_target_master #(
        .PWID_CYCLES (PWID),
        .PGAP_CYCLES (PGAP),
        .BREAK_CYCLES(BRK)
    ) dut (
        .fpga_clock_48mhz(clk),
        .reset_in        (reset_in),
        .bus             (bus),
        .testreq         (testreq),
        .testack         (testack)
    );

    always #10 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    // Adapter behaviour for the current command.
    logic       adp_sync_ack;
    logic       adp_ready;
    logic       adp_has_data;
    logic [7:0] adp_byte;
    // Expected rsp_data (last successfully received byte).
    logic [7:0] rx_model;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_total++;
        assert (obs === exp_v) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Value the adapter presents for pulse p of group grp; don't-care pulses get noise.
    function automatic logic ack_for(input logic [1:0] op, input int grp, input int p);
        logic r;
        r = 1'($urandom_range(0, 1));
        case (op)
            OP_SYNC:   if (p == 4) r = adp_sync_ack;
            OP_OUTPUT: if (grp == 0 && p == 3) r = adp_ready;
            OP_INPUT: begin
                if (p == 4) r = adp_has_data;
                else if (p >= 5 && p <= 12) r = adp_byte[12 - p];
            end
            default: r = r;
        endcase
        return r;
    endfunction

    // Issue one command at the current negedge and act as the adapter until completion.
    // abort_pulse > 0 asserts reset_in early in that pulse instead.
    task automatic run_cmd(input string name, input logic [1:0] op, input logic [7:0] d, input int abort_pulse);
        int grp_q[$];
        int exp_q[$];
        int k, high_len, low_len, pcnt, bad_high, bad_low, bad_busy, bad_quiet;
        logic prev_tr, tr, want, got_rsp, first_tr, obs_ok;
        logic [7:0] obs_data, recon;
        logic exp_ok;

        // Expected group structure and status from the protocol rules.
        case (op)
            OP_SYNC:   begin exp_q.push_back(4);  exp_ok = adp_sync_ack; end
            OP_CLEAR:  begin exp_q.push_back(12); exp_ok = 1'b0; end
            OP_OUTPUT: begin
                exp_q.push_back(3);
                exp_ok = adp_ready;
                if (adp_ready)
                    for (int i = 7; i >= 0; i--) exp_q.push_back(d[i] ? 1 : 2);
            end
            default: begin
                exp_q.push_back(adp_has_data ? 12 : 4);
                exp_ok = adp_has_data;
            end
        endcase

        check({name, "_ready_in"}, bus.cmd_ready, 1);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_data  = d;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'($urandom);
        bus.cmd_data  = 8'($urandom);

        prev_tr = 1'b0; high_len = 0; low_len = 0; pcnt = 0; want = 1'b0;
        bad_high = 0; bad_low = 0; bad_busy = 0; got_rsp = 1'b0;
        obs_ok = 1'b0; obs_data = 8'd0; first_tr = 1'b0;
        k = 0;
        while (k < MAX_CYCLES && !got_rsp) begin
            tr = testreq;
            if (k == 0) first_tr = tr;
            if (tr && !prev_tr) begin
                if (pcnt == 0 || low_len == BRK) begin
                    if (pcnt > 0) grp_q.push_back(pcnt);
                    pcnt = 1;
                end else begin
                    if (low_len != PGAP) bad_low++;
                    pcnt++;
                end
                high_len = 1;
                want = ack_for(op, grp_q.size(), pcnt);
                testack = 1'($urandom_range(0, 1));
            end else if (tr) begin
                high_len++;
                if (high_len == 8) testack = want;
            end else if (prev_tr) begin
                if (high_len != PWID) bad_high++;
                low_len = 1;
                testack = 1'($urandom_range(0, 1));
            end else begin
                low_len++;
            end
            prev_tr = tr;

            if (bus.busy !== 1'b1 || bus.cmd_ready !== 1'b0) bad_busy++;
            if (k == 30) begin bus.cmd_valid = 1'b1; bus.cmd_op = 2'($urandom); end
            if (k == 60) bus.cmd_valid = 1'b0;

            if (bus.rsp_valid === 1'b1) begin
                got_rsp  = 1'b1;
                obs_ok   = bus.rsp_ok;
                obs_data = bus.rsp_data;
                grp_q.push_back(pcnt);
                check({name, "_final_break"}, low_len, BRK + 1);
            end

            if (abort_pulse > 0 && pcnt == abort_pulse && tr && high_len == 3) begin
                reset_in = 1'b1;
                @(negedge clk);
                check({name, "_abort_testreq"}, testreq, 0);
                check({name, "_abort_status"}, {bus.rsp_valid, bus.busy, bus.cmd_ready}, 3'b001);
                reset_in = 1'b0;
                rx_model = 8'd0;
                bad_quiet = 0;
                for (int j = 0; j < BRK + 100; j++) begin
                    @(negedge clk);
                    if (bus.rsp_valid !== 1'b0 || testreq !== 1'b0) bad_quiet++;
                end
                check({name, "_abort_quiet"}, bad_quiet, 0);
                check({name, "_abort_rsp_data"}, bus.rsp_data, rx_model);
                return;
            end

            if (!got_rsp) @(negedge clk);
            k++;
        end

        check({name, "_first_rise"}, first_tr, 1);
        check({name, "_rsp_seen"}, got_rsp, 1);
        if (got_rsp) begin
            check({name, "_high_widths"}, bad_high, 0);
            check({name, "_gap_widths"}, bad_low, 0);
            check({name, "_busy_held"}, bad_busy, 0);
            check({name, "_rsp_ok"}, obs_ok, exp_ok);
            if (op == OP_INPUT && adp_has_data) rx_model = adp_byte;
            check({name, "_rsp_data"}, obs_data, rx_model);
            check({name, "_groups"}, grp_q.size(), exp_q.size());
            for (int i = 0; i < grp_q.size() && i < exp_q.size(); i++)
                check($sformatf("%s_grp%0d", name, i), grp_q[i], exp_q[i]);
            if (op == OP_OUTPUT && adp_ready && grp_q.size() == 9) begin
                recon = 8'd0;
                for (int i = 1; i < 9; i++) recon = {recon[6:0], grp_q[i] == 1};
                check({name, "_adapter_byte"}, recon, d);
            end
            @(negedge clk);
            check({name, "_after_resp"}, {bus.rsp_valid, bus.busy, bus.cmd_ready}, 3'b001);
        end
    endtask

    initial begin
        reset_in      = 1'b1;
        testack       = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'd0;
        bus.cmd_data  = 8'd0;
        adp_sync_ack  = 1'b0;
        adp_ready     = 1'b0;
        adp_has_data  = 1'b0;
        adp_byte      = 8'd0;
        rx_model      = 8'd0;
        repeat (3) @(negedge clk);
        check("reset_testreq", testreq, 0);
        check("reset_status", {bus.rsp_valid, bus.rsp_ok, bus.busy, bus.cmd_ready}, 4'b0001);
        check("reset_rsp_data", bus.rsp_data, 0);
        reset_in = 1'b0;

        adp_sync_ack = 1'b0;
        run_cmd("sync0", OP_SYNC, 8'($urandom), 0);
        adp_sync_ack = 1'b1;
        run_cmd("sync1", OP_SYNC, 8'($urandom), 0);
        run_cmd("clear", OP_CLEAR, 8'($urandom), 0);

        adp_ready = 1'b1;
        run_cmd("out_a8", OP_OUTPUT, 8'hA8, 0);
        run_cmd("out_rand", OP_OUTPUT, 8'($urandom), 0);
        adp_ready = 1'b0;
        run_cmd("out_notready", OP_OUTPUT, 8'($urandom), 0);

        adp_has_data = 1'b1;
        adp_byte = 8'h42;
        run_cmd("in_42", OP_INPUT, 8'($urandom), 0);
        adp_byte = 8'hC3;
        run_cmd("in_c3", OP_INPUT, 8'($urandom), 0);
        adp_has_data = 1'b0;
        adp_byte = 8'($urandom);
        run_cmd("in_empty", OP_INPUT, 8'($urandom), 0);
        adp_has_data = 1'b1;
        adp_byte = 8'($urandom);
        run_cmd("in_rand", OP_INPUT, 8'($urandom), 0);

        adp_byte = 8'($urandom);
        run_cmd("in_abort", OP_INPUT, 8'($urandom), 6);

        adp_sync_ack = 1'($urandom_range(0, 1));
        run_cmd("sync_after", OP_SYNC, 8'($urandom), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
